// File: rtl/ir_segmented_if.sv
// Segment-load bus between memory data path and the segmented IR: control and handshake in, register state out.
interface ir_segmented_if #(
   parameter int NBits   = 16,
   parameter int SegBits = 8
);
   localparam int SelBits = $clog2(NBits / SegBits);

   logic               e;
   logic [1:0]         funsel;
   logic               auto;
   logic [SelBits-1:0] seg_sel;
   logic [SegBits-1:0] i_seg;
   logic               in_valid;
   logic               in_ready;
   logic [NBits-1:0]   ir_out;
   logic               ir_valid;
   logic [SelBits-1:0] seg_cnt;

   modport master (
      output e, funsel, auto, seg_sel, i_seg, in_valid,
      input  in_ready, ir_out, ir_valid, seg_cnt
   );

   modport slave (
      input  e, funsel, auto, seg_sel, i_seg, in_valid,
      output in_ready, ir_out, ir_valid, seg_cnt
   );
endinterface

// File: rtl/ir_segmented.sv
// Instruction register filled SegBits at a time (manual select or counter-sequenced); IR_MSB_FIRST_EN reverses auto order.
// Accepted beat visible on ir_out next edge, ir_valid with the last auto beat; in_ready is combinational, drops when FULL or seg_sel out of range.
module ir_segmented #(
   parameter int NBits   = 16,
   parameter int SegBits = 8
) (
   input logic           clk,
   input logic           rst_n,
   ir_segmented_if.slave bus
);
   localparam int NSeg    = NBits / SegBits;
   localparam int SelBits = $clog2(NSeg);
   localparam logic [SelBits:0]   NSEG_W = (SelBits + 1)'(NSeg);
   localparam logic [SelBits-1:0] LAST   = SelBits'(NSeg - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [SelBits-1:0] cnt, cnt_nxt;
   logic               vld, vld_nxt;
   logic [NBits-1:0]   ir, ir_nxt;
   logic               load, in_ready, accept;
   logic [SelBits-1:0] auto_idx, wr_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         vld   <= 1'b0;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         vld   <= vld_nxt;
         ir    <= ir_nxt;
      end
   end

`ifdef IR_MSB_FIRST_EN
   assign auto_idx = LAST - cnt;
`else
   assign auto_idx = cnt;
`endif
   assign wr_idx = bus.auto ? auto_idx : bus.seg_sel;
   assign accept = in_ready && bus.in_valid;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      vld_nxt   = vld;
      ir_nxt    = ir;
      if (bus.e) begin
         case (bus.funsel)
            2'b00: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               vld_nxt   = 1'b0;
               ir_nxt    = '0;
            end
            2'b11: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               vld_nxt   = 1'b0;
            end
            2'b01: begin
               if (accept) begin
                  ir_nxt[wr_idx*SegBits +: SegBits] = bus.i_seg;
                  // manual beats never touch the sequencer, so a paused fill resumes where it left off
                  if (bus.auto) begin
                     case (state)
                        IDLE: begin
                           cnt_nxt   = cnt + 1'b1;
                           state_nxt = FILL;
                        end
                        FILL: begin
                           if (cnt == LAST) begin
                              cnt_nxt   = '0;
                              state_nxt = FULL;
                              vld_nxt   = 1'b1;
                           end else begin
                              cnt_nxt = cnt + 1'b1;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      load     = bus.e && (bus.funsel == 2'b01);
      in_ready = 1'b0;
      if (load)
         in_ready = bus.auto ? (state != FULL) : ({1'b0, bus.seg_sel} < NSEG_W);
   end

   assign bus.in_ready = in_ready;
   assign bus.ir_out   = ir;
   assign bus.ir_valid = vld;
   assign bus.seg_cnt  = cnt;
endmodule
